// File: rtl/pipe_adder_pkg.sv
// Shared constants and stage-count helper for the chunked pipelined adder.
package pipe_adder_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CHUNK = 4;

   function automatic int nstage(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One CHUNK-bit slice of the carry pipeline: registered sum, carry and valid.
module adder_chunk_stage
   import pipe_adder_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             vld_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   output logic             vld_o,
   output logic [CHUNK-1:0] s_o,
   output logic             c_o
);

   logic             vld_d, vld_q;
   logic             c_d, c_q;
   logic [CHUNK-1:0] s_d, s_q;

   always_comb begin
      vld_d      = vld_i;
      {c_d, s_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= 1'b0;
         c_q   <= 1'b0;
         s_q   <= '0;
      end else if (en_i) begin
         vld_q <= vld_d;
         c_q   <= c_d;
         s_q   <= s_d;
      end
   end

   assign vld_o = vld_q;
   assign s_o   = s_q;
   assign c_o   = c_q;

endmodule

// File: rtl/pipe_nbit_adder.sv
// Pipelined ripple adder, one CHUNK per stage, skewed operands, de-skewed sum.
// Define ADDER_SUB_EN to add the sub port (a - b - cin, cout = no borrow).
module pipe_nbit_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTAGE = nstage(WIDTH, CHUNK);
   localparam int LAST   = NSTAGE - 1;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   logic [WIDTH-1:0] a_st  [NSTAGE];
   logic [WIDTH-1:0] b_st  [NSTAGE];
   logic [WIDTH-1:0] lo_st [NSTAGE];
   logic [CHUNK-1:0] s_st  [NSTAGE];
   logic             c_st  [NSTAGE];
   logic             v_st  [NSTAGE];

   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

`ifdef ADDER_SUB_EN
   // Inverted B travels with its transaction, so sub needs no own register.
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~cin : cin;
`else
   assign b_eff = b;
   assign c_eff = cin;
`endif

   for (genvar k = 0; k < NSTAGE; k++) begin : g_st
      logic [WIDTH-1:0] a_d, b_d, lo_d;
      logic [WIDTH-1:0] a_q, b_q, lo_q;
      logic             c_d, v_d;

      if (k == 0) begin : g_first
         assign a_d  = a;
         assign b_d  = b_eff;
         assign lo_d = '0;
         assign c_d  = c_eff;
         assign v_d  = in_valid;
      end else begin : g_next
         assign a_d  = a_st[k-1];
         assign b_d  = b_st[k-1];
         assign lo_d = lo_st[k-1] |
                       (WIDTH'(s_st[k-1]) << ((k-1)*CHUNK));
         assign c_d  = c_st[k-1];
         assign v_d  = v_st[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            lo_q <= '0;
         end else if (adv) begin
            a_q  <= a_d;
            b_q  <= b_d;
            lo_q <= lo_d;
         end
      end

      assign a_st[k]  = a_q;
      assign b_st[k]  = b_q;
      assign lo_st[k] = lo_q;

      adder_chunk_stage #(
         .CHUNK (CHUNK)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .en_i  (adv),
         .vld_i (v_d),
         .a_i   (a_d[k*CHUNK +: CHUNK]),
         .b_i   (b_d[k*CHUNK +: CHUNK]),
         .c_i   (c_d),
         .vld_o (v_st[k]),
         .s_o   (s_st[k]),
         .c_o   (c_st[k])
      );
   end

   assign out_valid = v_st[LAST];
   assign sum       = lo_st[LAST] | (WIDTH'(s_st[LAST]) << (LAST*CHUNK));
   assign cout      = c_st[LAST];
   assign ovf       = (a_st[LAST][WIDTH-1] == b_st[LAST][WIDTH-1]) &
                      (sum[WIDTH-1] != a_st[LAST][WIDTH-1]);

   // Only the sign bits of the final operand copies feed the result.
   logic unused_ok;
   assign unused_ok = ^{a_st[LAST][WIDTH-2:0], b_st[LAST][WIDTH-2:0]};

endmodule

// File: tb/tb_pipe_nbit_adder.sv
// Directed scoreboard bench for pipe_nbit_adder (WIDTH=8, CHUNK=4).
module tb_pipe_nbit_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int nout   = 0;

   logic [W+1:0] exp_q[$];
   int           out_cyc[$];

   always #5 clk = ~clk;

   pipe_nbit_adder #(
      .WIDTH (8),
      .CHUNK (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   function automatic logic [W+1:0] model(input logic [W-1:0] ta,
                                          input logic [W-1:0] tb,
                                          input logic tc,
                                          input logic ts);
      logic [W-1:0] bb;
      logic         cc;
      logic [W:0]   r;
      logic         v;
      bb = ts ? ~tb : tb;
      cc = ts ? ~tc : tc;
      r  = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, cc};
      v  = (ta[W-1] == bb[W-1]) && (r[W-1] != ta[W-1]);
      return {v, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         chk("result_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0)
            chk("result", 32'({ovf, cout, sum}), 32'(exp_q.pop_front()));
         nout++;
         out_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts);
      logic acc;
      a        = ta;
      b        = tb;
      cin      = tc;
      sub      = ts;
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(model(ta, tb, tc, ts));
      #1;
   endtask

   initial begin
      int base;
      int n0;
      logic [W+1:0] held;
      logic [W-1:0] ra, rb;
      logic         rc, rs;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (2) step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs", 32'({ovf, cout, sum}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      step();

      // Latency: valid appears after exactly two accepting edges.
      send(8'hF0, 8'hFF, 1'b1, 1'b0);
      idle();
      chk("lat_not_yet", 32'(out_valid), 32'd0);
      step();
      chk("lat_valid", 32'(out_valid), 32'd1);
      step();
      chk("lat_drained", 32'(out_valid), 32'd0);

      send(8'h7F, 8'h01, 1'b0, 1'b0);
      send(8'h00, 8'h00, 1'b1, 1'b0);
      idle();
      repeat (3) step();

      // Back-to-back burst.
      base = nout;
      n0   = out_cyc.size();
      send(8'h01, 8'h01, 1'b0, 1'b0);
      send(8'h0F, 8'h01, 1'b0, 1'b0);
      send(8'hFF, 8'h01, 1'b0, 1'b0);
      send(8'h80, 8'h80, 1'b0, 1'b0);
      idle();
      repeat (3) step();
      chk("burst_count", 32'(nout - base), 32'd4);
      if (out_cyc.size() >= n0 + 4)
         chk("burst_consec", 32'(out_cyc[n0+3] - out_cyc[n0]), 32'd3);

      // Back-pressure with a full pipeline.
      out_ready = 1'b0;
      base = nout;
      send(8'h11, 8'h22, 1'b0, 1'b0);
      send(8'h33, 8'h44, 1'b1, 1'b0);
      held     = {ovf, cout, sum};
      a        = 8'h55;
      b        = 8'h66;
      cin      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_value", 32'({ovf, cout, sum}),
             32'(model(8'h11, 8'h22, 1'b0, 1'b0)));
         chk("stall_stable", 32'({ovf, cout, sum}), 32'(held));
         step();
      end
      out_ready = 1'b1;
      send(8'h55, 8'h66, 1'b0, 1'b0);
      idle();
      repeat (4) step();
      chk("stall_count", 32'(nout - base), 32'd3);
      chk("stall_queue", 32'(exp_q.size()), 32'd0);

      // Reset with two transactions in flight.
      base = nout;
      send(8'h01, 8'h02, 1'b0, 1'b0);
      send(8'h03, 8'h04, 1'b0, 1'b0);
      idle();
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_outputs", 32'({ovf, cout, sum}), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      step();
      rst = 1'b0;
      repeat (4) step();
      chk("midrst_no_stale", 32'(nout - base), 32'd0);
      send(8'h0A, 8'h05, 1'b0, 1'b0);
      idle();
      chk("postrst_not_yet", 32'(out_valid), 32'd0);
      step();
      chk("postrst_valid", 32'(out_valid), 32'd1);
      step();

`ifdef ADDER_SUB_EN
      send(8'h05, 8'h07, 1'b0, 1'b1);
      send(8'h80, 8'h01, 1'b0, 1'b1);
      idle();
      repeat (3) step();
`endif

      // Mixed traffic with random back-pressure and bubbles.
      for (int i = 0; i < 40; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         if ($urandom_range(0, 3) == 0) begin
            idle();
            step();
         end else begin
            send(ra, rb, rc, rs);
         end
      end
      idle();
      out_ready = 1'b1;
      repeat (5) step();
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
